// File: rtl/nrs_multi_ant_ls_est.sv
// NRS least-squares channel estimator: rx * conj(QPSK pilot) into per-port estimate buffers.
// Optional NRS_AVG_EN: two passes per buffer, second pass averages with the stored estimate.
module nrs_multi_ant_ls_est #(
    parameter int WIDTH_R_I = 16,
    parameter int PILOT_FLOAT_BITS = 11,
    parameter logic signed [11:0] VALUE = 12'sb0_1011010_1000,
    parameter int NUM_ANT = 2,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = (NUM_ANT > 1) ? $clog2(NUM_ANT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PW-1:0]              in_ant,
    input  logic signed [WIDTH_R_I-1:0] rx_r,
    input  logic signed [WIDTH_R_I-1:0] rx_i,
    input  logic                       nrs_r,
    input  logic                       nrs_i,
    output logic                       est_valid,
    output logic signed [WIDTH_R_I:0]  est_r,
    output logic signed [WIDTH_R_I:0]  est_i,
    output logic [PW-1:0]              est_ant,
    output logic [AW-1:0]              est_addr,
    output logic [NUM_ANT-1:0]         full,
    output logic                       done,
    input  logic [PW-1:0]              rd_ant,
    input  logic [AW-1:0]              rd_addr,
    output logic signed [WIDTH_R_I:0]  rd_r,
    output logic signed [WIDTH_R_I:0]  rd_i
);
`ifdef NRS_AVG_EN
    localparam int QUOTA = 2 * DEPTH;
`else
    localparam int QUOTA = DEPTH;
`endif
    localparam int CW = $clog2(QUOTA + 1);
    localparam int SW = WIDTH_R_I + 1;
    localparam int PRW = WIDTH_R_I + 13;

    function automatic logic signed [SW-1:0] scale(input logic signed [PRW-1:0] p);
        logic signed [PRW-1:0] s;
        s = p >>> PILOT_FLOAT_BITS;
        return s[SW-1:0];
    endfunction

`ifdef NRS_AVG_EN
    function automatic logic signed [SW-1:0] avg2(input logic signed [SW-1:0] x,
                                                  input logic signed [SW-1:0] y);
        logic signed [SW:0] s;
        s = (SW + 1)'(x) + (SW + 1)'(y);
        s = s >>> 1;
        return s[SW-1:0];
    endfunction
`endif

    logic [CW-1:0]         cnt [NUM_ANT];
    logic [NUM_ANT-1:0]    full_q;
    logic                  accept;
    logic [CW-1:0]         cur_cnt;
    logic [AW-1:0]         cur_addr;
    logic signed [SW-1:0]  xr, xi, sum_a, sum_b;
    logic signed [SW-1:0]  a_p1, b_p1;
    logic [PW-1:0]         ant_p1, ant_p2;
    logic [AW-1:0]         addr_p1, addr_p2;
    logic                  vld_p1, vld_p2;
    logic signed [PRW-1:0] prod_a_p2, prod_b_p2;
    logic signed [SW-1:0]  wr_r, wr_i;
    logic signed [SW-1:0]  mem_r [NUM_ANT][DEPTH];
    logic signed [SW-1:0]  mem_i [NUM_ANT][DEPTH];
`ifdef NRS_AVG_EN
    logic                  cur_pass2, pass_p1, pass_p2;
`endif

    assign in_ready = ~full_q[in_ant] & ~clear;
    assign accept   = in_valid & in_ready;
    assign full     = full_q;
    assign done     = (&full_q) & ~vld_p1 & ~vld_p2;
    assign rd_r     = mem_r[rd_ant][rd_addr];
    assign rd_i     = mem_i[rd_ant][rd_addr];

    always_comb begin
        cur_cnt = cnt[in_ant];
`ifdef NRS_AVG_EN
        cur_pass2 = cur_cnt >= CW'(DEPTH);
        cur_addr  = cur_pass2 ? AW'(cur_cnt - CW'(DEPTH)) : AW'(cur_cnt);
`else
        cur_addr  = AW'(cur_cnt);
`endif
        xr    = SW'(rx_r);
        xi    = SW'(rx_i);
        sum_a = (nrs_r ? -xr : xr) + (nrs_i ? -xi : xi);
        sum_b = (nrs_r ? -xi : xi) - (nrs_i ? -xr : xr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_ANT; p++) cnt[p] <= '0;
            full_q    <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            est_valid <= 1'b0;
        end else if (clear) begin
            for (int p = 0; p < NUM_ANT; p++) cnt[p] <= '0;
            full_q    <= '0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            est_valid <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_ANT; p++) begin
                if (accept && in_ant == PW'(p)) begin
                    cnt[p]    <= cnt[p] + CW'(1);
                    full_q[p] <= (cnt[p] + CW'(1)) == CW'(QUOTA);
                end
            end
            vld_p1    <= accept;
            vld_p2    <= vld_p1;
            est_valid <= vld_p2;
        end
    end

    // stage 1: pilot de-rotation sums; stage 2: scaling products
    always_ff @(posedge clk) begin
        a_p1      <= sum_a;
        b_p1      <= sum_b;
        ant_p1    <= in_ant;
        addr_p1   <= cur_addr;
        prod_a_p2 <= PRW'(a_p1) * PRW'(VALUE);
        prod_b_p2 <= PRW'(b_p1) * PRW'(VALUE);
        ant_p2    <= ant_p1;
        addr_p2   <= addr_p1;
`ifdef NRS_AVG_EN
        pass_p1   <= cur_pass2;
        pass_p2   <= pass_p1;
`endif
    end

    always_comb begin
        wr_r = scale(prod_a_p2);
        wr_i = scale(prod_b_p2);
`ifdef NRS_AVG_EN
        if (pass_p2) begin
            wr_r = avg2(mem_r[ant_p2][addr_p2], scale(prod_a_p2));
            wr_i = avg2(mem_i[ant_p2][addr_p2], scale(prod_b_p2));
        end
`endif
    end

    // output stage: estimate register and buffer write; clear drops the in-flight write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            est_r    <= '0;
            est_i    <= '0;
            est_ant  <= '0;
            est_addr <= '0;
            for (int p = 0; p < NUM_ANT; p++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem_r[p][a] <= '0;
                    mem_i[p][a] <= '0;
                end
            end
        end else if (vld_p2 && !clear) begin
            est_r    <= wr_r;
            est_i    <= wr_i;
            est_ant  <= ant_p2;
            est_addr <= addr_p2;
            mem_r[ant_p2][addr_p2] <= wr_r;
            mem_i[ant_p2][addr_p2] <= wr_i;
        end
    end
endmodule
